spi_sram_master: RTL
====================

SPI_SRAM_MASTER -- requirements
Module: spi_sram_master

Interface
REQ-001 The block SHALL have the parameter INSTR_RD, default 8'h03, meaning the read opcode sent in the instruction byte.
REQ-002 The block SHALL have the parameter INSTR_WR, default 8'h02, meaning the write opcode sent in the instruction byte.
REQ-003 The block SHALL have the port clk, input, 1 bit: the single system clock; all logic runs on its rising edge.
REQ-004 The block SHALL have the port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have the port start, input, 1 bit: transaction request, sampled only in IDLE.
REQ-006 The block SHALL have the port WR, input, 1 bit: 1 = write, 0 = read, captured with start.
REQ-007 The block SHALL have the port addr, input, 8 bits: SRAM address, captured with start.
REQ-008 The block SHALL have the port wdata, input, 8 bits: write data, captured with start.
REQ-009 The block SHALL have the port MISO, input, 1 bit: serial data from the SRAM slave.
REQ-010 The block SHALL have the port SCK, output, 1 bit: serial clock (clk/4), idle low.
REQ-011 The block SHALL have the port ss, output, 1 bit: slave select, active low.
REQ-012 The block SHALL have the port MOSI, output, 1 bit: serial data to the slave.
REQ-013 The block SHALL have the port rdata, output, 8 bits: last completed read byte.
REQ-014 The block SHALL have the port busy, output, 1 bit: high from start acceptance until the done pulse, inclusive.
REQ-015 The block SHALL have the port done, output, 1 bit: one-clk completion pulse.

Function
REQ-016 The block SHALL accept start only in IDLE, registering WR, addr and wdata on the accepting edge; start while busy is ignored.
REQ-017 The state machine SHALL have the states IDLE, LEAD, INSTR, ADDR, DATA, COMMIT and FIN.
REQ-018 Transitions SHALL be: IDLE->LEAD on start; LEAD->INSTR after 1 SCK pulse; INSTR->ADDR after 8 pulses; ADDR->DATA after 8 pulses; DATA->COMMIT (WR=1) or DATA->FIN (WR=0) after 8 pulses; COMMIT->FIN after 1 pulse; FIN->IDLE after 1 clk.
REQ-019 ss SHALL go low in the clk after acceptance and stay low for exactly 4*N clk cycles, where N = 25 pulses for a read and N = 26 for a write.
REQ-020 Each SCK pulse SHALL be 4 clk long: 2 clk low followed by 2 clk high, generated by a 2-bit phase counter that resets to 0 on entering LEAD.
REQ-021 MOSI SHALL be valid before the first INSTR rising edge and change only on SCK falling edges (mode 0), MSB first.
REQ-022 MOSI SHALL carry the opcode (INSTR_WR or INSTR_RD) in INSTR, addr in ADDR, wdata in DATA when WR=1, and 0 in LEAD, COMMIT and read-DATA.
REQ-023 In DATA with WR=0, MISO SHALL be sampled on each SCK rising edge, MSB first, into a shift register.
REQ-024 rdata SHALL update only in FIN of a read and hold its value otherwise, including across writes.
REQ-025 In FIN, ss SHALL be high, SCK low, MOSI 0 and done 1 for one clk; busy SHALL drop in the following clk.
REQ-026 SCK SHALL be low whenever ss is high, with no glitches on SCK or ss; both SHALL be driven directly from flops.
REQ-027 A new start SHALL be accepted no earlier than the clk after FIN, giving back-to-back transactions at least 1 clk of ss high.

Reset
REQ-028 With rst_n=0 at a clk edge, the block SHALL go to IDLE with ss=1, SCK=0, MOSI=0, done=0, busy=0, rdata=8'h00 and all counters cleared.
REQ-029 A reset mid-frame SHALL abort the transaction with no done pulse and leave rdata unchanged from its pre-reset value unless the reset itself clears it per REQ-028.

Verification
REQ-030 Write test: start with WR=1, addr=8'h5A, wdata=8'hC3 -> ss low for 104 clk, 26 SCK pulses, MOSI bits 0,02h,5Ah,C3h,0, one done pulse.
REQ-031 Read test: start with WR=0, addr=8'h0F, slave model drives 8'hA5 -> ss low for 100 clk, 25 pulses, rdata=8'hA5 at done.
REQ-032 Ignored start: pulse start during ADDR of a read -> transaction unchanged; exactly one done.
REQ-033 Reset during DATA: drive rst_n=0 -> next clk ss=1, SCK=0, busy=0, no done.
REQ-034 Back-to-back: hold start high through a write then a read -> ss high for at least 1 clk between frames, rdata changes only after the read.
REQ-035 Loopback: run against the team's SRAM SPI slave, write 8'h3C to address 8'h10, then read address 8'h10 -> rdata=8'h3C.

Source files
------------

// File: rtl/spi_sram_master.sv
// SPI mode-0 master for a byte-wide serial SRAM: one instruction, one address and one data byte per frame.
// Latency: ss low for 4*25 clk on a read, 4*26 clk on a write, then one FIN clk carrying the done pulse.
// Backpressure: start is sampled only in IDLE; a start that arrives while busy is dropped.
module spi_sram_master #(
  parameter logic [7:0] INSTR_RD = 8'h03,
  parameter logic [7:0] INSTR_WR = 8'h02
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       WR,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic       MISO,
  output logic       SCK,
  output logic       ss,
  output logic       MOSI,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEAD   = 3'd1,
    INSTR  = 3'd2,
    ADDR   = 3'd3,
    DATA   = 3'd4,
    COMMIT = 3'd5,
    FIN    = 3'd6
  } state_t;

  state_t      r_state;
  logic [1:0]  r_phase;
  logic [2:0]  r_bit;
  logic        r_wr;
  logic [7:0]  r_addr;
  logic [7:0]  r_wdata;
  logic [7:0]  r_tx;
  logic [7:0]  r_rx;
  logic        r_sck;
  logic        r_ss;
  logic        r_mosi;
  logic [7:0]  r_rdata;
  logic        r_busy;
  logic        r_done;

  logic [1:0]  w_phase_nxt;
  logic        w_pulse_end;
  logic        w_last_bit;
  logic [7:0]  w_opcode;

  // Phase 0,1 = SCK low, 2,3 = SCK high; a pulse ends on the edge leaving phase 3,
  // which is also the SCK falling edge where MOSI is allowed to move.
  assign w_phase_nxt = r_phase + 2'd1;
  assign w_pulse_end = (r_phase == 2'd3);
  assign w_last_bit  = (r_bit == 3'd7);
  assign w_opcode    = r_wr ? INSTR_WR : INSTR_RD;

  assign SCK   = r_sck;
  assign ss    = r_ss;
  assign MOSI  = r_mosi;
  assign rdata = r_rdata;
  assign busy  = r_busy;
  assign done  = r_done;

  // Frame sequencer: every output is a flop so SCK and ss cannot glitch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_phase <= 2'd0;
      r_bit   <= 3'd0;
      r_wr    <= 1'b0;
      r_addr  <= 8'h00;
      r_wdata <= 8'h00;
      r_tx    <= 8'h00;
      r_rx    <= 8'h00;
      r_sck   <= 1'b0;
      r_ss    <= 1'b1;
      r_mosi  <= 1'b0;
      r_rdata <= 8'h00;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= LEAD;
            r_wr    <= WR;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_phase <= 2'd0;
            r_bit   <= 3'd0;
            r_sck   <= 1'b0;
            r_ss    <= 1'b0;
            r_mosi  <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        FIN: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_phase <= w_phase_nxt;
          r_sck   <= w_phase_nxt[1];
          // Read data is sampled on the SCK rising edge (leaving phase 1).
          if (r_state == DATA && !r_wr && r_phase == 2'd1) begin
            r_rx <= {r_rx[6:0], MISO};
          end
          if (w_pulse_end) begin
            r_bit <= r_bit + 3'd1;
            case (r_state)
              LEAD: begin
                r_state <= INSTR;
                r_bit   <= 3'd0;
                r_mosi  <= w_opcode[7];
                r_tx    <= {w_opcode[6:0], 1'b0};
              end
              INSTR: begin
                if (w_last_bit) begin
                  r_state <= ADDR;
                  r_mosi  <= r_addr[7];
                  r_tx    <= {r_addr[6:0], 1'b0};
                end else begin
                  r_mosi <= r_tx[7];
                  r_tx   <= {r_tx[6:0], 1'b0};
                end
              end
              ADDR: begin
                if (w_last_bit) begin
                  r_state <= DATA;
                  // A read drives zeros while the slave returns data.
                  r_mosi  <= r_wr & r_wdata[7];
                  r_tx    <= r_wr ? {r_wdata[6:0], 1'b0} : 8'h00;
                end else begin
                  r_mosi <= r_tx[7];
                  r_tx   <= {r_tx[6:0], 1'b0};
                end
              end
              DATA: begin
                if (w_last_bit) begin
                  r_mosi <= 1'b0;
                  if (r_wr) begin
                    r_state <= COMMIT;
                  end else begin
                    r_state <= FIN;
                    r_ss    <= 1'b1;
                    r_done  <= 1'b1;
                    r_rdata <= r_rx;
                  end
                end else begin
                  r_mosi <= r_tx[7];
                  r_tx   <= {r_tx[6:0], 1'b0};
                end
              end
              COMMIT: begin
                r_state <= FIN;
                r_ss    <= 1'b1;
                r_mosi  <= 1'b0;
                r_done  <= 1'b1;
              end
              default: begin
                r_state <= IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule
